// File: rtl/wb_dual_master_arbiter.sv
// Two-master Wishbone arbiter: management SoC (M0) and LA debug requester (M1)
// share one core slave port with round-robin grant and watchdog abort.
module wb_dual_master_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TO_W    = 8,
   parameter int TIMEOUT = 255
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_ni,
   input  logic              wbs_cyc_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_we_i,
   input  logic [DW/8-1:0]   wbs_sel_i,
   input  logic [AW-1:0]     wbs_adr_i,
   input  logic [DW-1:0]     wbs_dat_i,
   output logic              wbs_ack_o,
   output logic              wbs_err_o,
   output logic [DW-1:0]     wbs_dat_o,
   input  logic              la_req_i,
   input  logic              la_we_i,
   input  logic [AW-1:0]     la_adr_i,
   input  logic [DW-1:0]     la_dat_i,
   output logic              la_ack_o,
   output logic              la_err_o,
   output logic [DW-1:0]     la_dat_o,
   output logic              m_cyc_o,
   output logic              m_stb_o,
   output logic              m_we_o,
   output logic [DW/8-1:0]   m_sel_o,
   output logic [AW-1:0]     m_adr_o,
   output logic [DW-1:0]     m_dat_o,
   input  logic [DW-1:0]     m_dat_i,
   input  logic              m_ack_i,
   output logic [1:0]        grant_o,
   output logic              timeout_irq_o
);

   typedef enum logic [1:0] {IDLE, BUSY0, BUSY1, ERR} state_t;

   localparam logic [TO_W-1:0] TO_VAL = TO_W'(TIMEOUT);

   state_t          state;
   logic            last_q;
   logic [TO_W-1:0] cnt;
   logic            cyc_q;
   logic [1:0]      grant_q;
   logic            err0_q;
   logic            err1_q;
   logic            irq_q;

   logic            r0;
   logic            r1;
   logic            own_req;
   logic            to_hit;

   assign r0 = wbs_cyc_i & wbs_stb_i;
   assign r1 = la_req_i;

   // Owner still holding its request; a drop means abandon and masks m_ack_i.
   assign own_req = (state == BUSY0) ? wbs_cyc_i :
                    (state == BUSY1) ? la_req_i  : 1'b0;
   assign to_hit  = (TIMEOUT != 0) && (cnt == TO_VAL);

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state   <= IDLE;
         last_q  <= 1'b1;
         cnt     <= '0;
         cyc_q   <= 1'b0;
         grant_q <= 2'b00;
         err0_q  <= 1'b0;
         err1_q  <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               // last_q == 1 means M1 went last, so M0 takes the tie.
               if (r0 && (!r1 || last_q)) begin
                  state   <= BUSY0;
                  cyc_q   <= 1'b1;
                  grant_q <= 2'b01;
               end else if (r1) begin
                  state   <= BUSY1;
                  cyc_q   <= 1'b1;
                  grant_q <= 2'b10;
               end
            end
            BUSY0, BUSY1: begin
               if (!own_req || m_ack_i) begin
                  state   <= IDLE;
                  last_q  <= (state == BUSY1);
                  cnt     <= '0;
                  cyc_q   <= 1'b0;
                  grant_q <= 2'b00;
               end else if (to_hit) begin
                  state  <= ERR;
                  cnt    <= '0;
                  cyc_q  <= 1'b0;
                  err0_q <= (state == BUSY0);
                  err1_q <= (state == BUSY1);
                  irq_q  <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ERR: begin
               state   <= IDLE;
               last_q  <= grant_q[1];
               grant_q <= 2'b00;
               err0_q  <= 1'b0;
               err1_q  <= 1'b0;
               irq_q   <= 1'b0;
            end
         endcase
      end
   end

   assign m_cyc_o       = cyc_q;
   assign m_stb_o       = cyc_q;
   assign grant_o       = grant_q;
   assign wbs_err_o     = err0_q;
   assign la_err_o      = err1_q;
   assign timeout_irq_o = irq_q;

   assign wbs_ack_o = (state == BUSY0) & own_req & m_ack_i;
   assign la_ack_o  = (state == BUSY1) & own_req & m_ack_i;
   assign wbs_dat_o = wbs_ack_o ? m_dat_i : '0;
   assign la_dat_o  = la_ack_o  ? m_dat_i : '0;

   always_comb begin
      m_we_o  = 1'b0;
      m_sel_o = '0;
      m_adr_o = '0;
      m_dat_o = '0;
      if (state == BUSY0) begin
         m_we_o  = wbs_we_i;
         m_sel_o = wbs_sel_i;
         m_adr_o = wbs_adr_i;
         m_dat_o = wbs_dat_i;
      end else if (state == BUSY1) begin
         m_we_o  = la_we_i;
         m_sel_o = '1;
         m_adr_o = la_adr_i;
         m_dat_o = la_dat_i;
      end
   end

endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// Scoreboarded bench: directed stimulus pushes expected master responses,
// a negedge monitor pops and compares whenever any ack/err appears.
module tb_wb_dual_master_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wbs_cyc, wbs_stb, wbs_we;
   logic [3:0]  wbs_sel;
   logic [31:0] wbs_adr, wbs_dat;
   logic        wbs_ack, wbs_err;
   logic [31:0] wbs_rdat;
   logic        la_req, la_we;
   logic [31:0] la_adr, la_dat;
   logic        la_ack, la_err;
   logic [31:0] la_rdat;
   logic        m_cyc, m_stb, m_we;
   logic [3:0]  m_sel;
   logic [31:0] m_adr, m_dat, m_rdat;
   logic        m_ack;
   logic [1:0]  grant;
   logic        irq;

   wb_dual_master_arbiter dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n),
      .wbs_cyc_i(wbs_cyc), .wbs_stb_i(wbs_stb), .wbs_we_i(wbs_we),
      .wbs_sel_i(wbs_sel), .wbs_adr_i(wbs_adr), .wbs_dat_i(wbs_dat),
      .wbs_ack_o(wbs_ack), .wbs_err_o(wbs_err), .wbs_dat_o(wbs_rdat),
      .la_req_i(la_req), .la_we_i(la_we), .la_adr_i(la_adr), .la_dat_i(la_dat),
      .la_ack_o(la_ack), .la_err_o(la_err), .la_dat_o(la_rdat),
      .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_we_o(m_we), .m_sel_o(m_sel),
      .m_adr_o(m_adr), .m_dat_o(m_dat), .m_dat_i(m_rdat), .m_ack_i(m_ack),
      .grant_o(grant), .timeout_irq_o(irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        who;
      logic        err;
      logic [31:0] dat;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;
   logic [3:0]  exp_fl;
   logic [63:0] exp_dt;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_resp(input logic who, input logic err, input logic [31:0] dat);
      exp_t x;
      x.who = who; x.err = err; x.dat = dat;
      q.push_back(x);
   endtask

   // Monitor: any response must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && (wbs_ack || wbs_err || la_ack || la_err)) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL resp_unexpected actual ack0=%0b err0=%0b ack1=%0b err1=%0b expected none",
                     wbs_ack, wbs_err, la_ack, la_err);
         end else begin
            e      = q.pop_front();
            exp_fl = e.who ? {2'b00, !e.err, e.err} : {!e.err, e.err, 2'b00};
            exp_dt = e.err ? 64'h0 : (e.who ? {32'h0, e.dat} : {e.dat, 32'h0});
            if ({wbs_ack, wbs_err, la_ack, la_err} !== exp_fl || {wbs_rdat, la_rdat} !== exp_dt) begin
               errors++;
               $display("FAIL resp actual flags=%b dat=%h expected flags=%b dat=%h",
                        {wbs_ack, wbs_err, la_ack, la_err}, {wbs_rdat, la_rdat}, exp_fl, exp_dt);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n = 1'b0;
      wbs_cyc = 0; wbs_stb = 0; wbs_we = 0; wbs_sel = 4'hF; wbs_adr = 0; wbs_dat = 0;
      la_req = 0; la_we = 0; la_adr = 0; la_dat = 0;
      m_rdat = 0; m_ack = 0;
      tick; tick;
      chk("rst_ctl", {m_cyc, m_stb, m_we, m_sel, grant, wbs_ack, wbs_err, la_ack, la_err, irq}, 0);
      chk("rst_bus", m_adr | m_dat | wbs_rdat | la_rdat, 0);
      rst_n = 1'b1;
      tick;

      // M0 read, acked on 2nd BUSY cycle
      wbs_cyc = 1; wbs_stb = 1; wbs_we = 0; wbs_adr = 32'h3000_0004;
      #1;
      chk("t1_cyc_lat", {m_cyc, grant}, {1'b0, 2'b00});
      tick;
      chk("t1_busy1", {m_cyc, m_stb, grant}, {1'b1, 1'b1, 2'b01});
      chk("t1_adr", m_adr, 32'h3000_0004);
      tick;
      m_ack = 1; m_rdat = 32'hDEAD_BEEF;
      expect_resp(0, 0, 32'hDEAD_BEEF);
      tick;
      m_ack = 0; wbs_cyc = 0; wbs_stb = 0;
      chk("t1_idle", {m_cyc, grant}, {1'b0, 2'b00});

      // Simultaneous requests from a fresh reset alternate M0, M1, M0, M1
      rst_n = 0; tick; rst_n = 1; tick;
      wbs_cyc = 1; wbs_stb = 1; wbs_adr = 32'hA0;
      la_req = 1; la_we = 1; la_adr = 32'hA1; la_dat = 32'h55;
      for (int i = 0; i < 4; i++) begin
         tick;
         chk("t2_grant", grant, (i % 2 == 0) ? 2'b01 : 2'b10);
         m_ack = 1; m_rdat = 32'h100 + i;
         expect_resp((i % 2 == 1), 0, 32'h100 + i);
         tick;
         m_ack = 0;
         chk("t2_idle_gap", grant, 2'b00);
         if (i == 3) begin
            wbs_cyc = 0; wbs_stb = 0; la_req = 0;
         end
      end
      tick;

      // M1 write with M0 arriving mid-transfer
      la_req = 1; la_we = 1; la_adr = 32'h10; la_dat = 32'h1234_5678;
      tick;
      chk("t3_m1_bus", {grant, m_we, m_sel, m_adr, m_dat}, {2'b10, 1'b1, 4'hF, 32'h10, 32'h1234_5678});
      wbs_cyc = 1; wbs_stb = 1; wbs_we = 0; wbs_sel = 4'h3; wbs_adr = 32'h20;
      tick;
      chk("t3_stable2", {grant, m_sel, m_adr}, {2'b10, 4'hF, 32'h10});
      tick;
      chk("t3_stable3", {grant, m_sel, m_adr}, {2'b10, 4'hF, 32'h10});
      m_ack = 1; m_rdat = 32'hCAFE_0000;
      expect_resp(1, 0, 32'hCAFE_0000);
      tick;
      m_ack = 0; la_req = 0;
      chk("t3_gap", {m_cyc, grant}, {1'b0, 2'b00});
      tick;
      chk("t3_m0_grant", {grant, m_sel, m_adr}, {2'b01, 4'h3, 32'h20});
      m_ack = 1; m_rdat = 32'h0BAD_F00D;
      expect_resp(0, 0, 32'h0BAD_F00D);
      tick;
      m_ack = 0; wbs_cyc = 0; wbs_stb = 0;
      tick;

      // Timeout: core never acks
      wbs_cyc = 1; wbs_stb = 1; wbs_adr = 32'h40;
      expect_resp(0, 1, 32'h0);
      tick;
      n = 0;
      while (m_cyc && n < 300) begin
         n++;
         tick;
      end
      chk("t4_busy_cycles", n, 256);
      chk("t4_err_cycle", {m_cyc, wbs_err, la_err, irq, grant}, {1'b0, 1'b1, 1'b0, 1'b1, 2'b01});
      wbs_cyc = 0; wbs_stb = 0;
      tick;
      chk("t4_after_err", {wbs_err, irq, grant}, {1'b0, 1'b0, 2'b00});
      m_ack = 1; m_rdat = 32'h1;
      #1;
      chk("t4_stray_ack", {wbs_ack, la_ack}, 2'b00);
      tick;
      m_ack = 0;

      // M0 abandons in 3rd BUSY cycle, ack in that cycle is not forwarded
      wbs_cyc = 1; wbs_stb = 1; wbs_adr = 32'h50;
      tick; tick; tick;
      wbs_cyc = 0; wbs_stb = 0; m_ack = 1; m_rdat = 32'h2;
      #1;
      chk("t5_abandon_ack", {wbs_ack, wbs_err}, 2'b00);
      tick;
      m_ack = 0;
      chk("t5_drop", {m_cyc, grant}, {1'b0, 2'b00});
      wbs_cyc = 1; wbs_stb = 1; la_req = 1; la_we = 0; la_adr = 32'h60;
      tick;
      chk("t5_m1_next", grant, 2'b10);
      m_ack = 1; m_rdat = 32'h3;
      expect_resp(1, 0, 32'h3);
      tick;
      m_ack = 0; wbs_cyc = 0; wbs_stb = 0; la_req = 0;
      tick;

      // Asynchronous reset mid-BUSY1
      la_req = 1; la_adr = 32'h70;
      tick;
      chk("t6_busy1", {m_cyc, grant}, {1'b1, 2'b10});
      #2;
      rst_n = 0;
      #1;
      chk("t6_async_ctl", {m_cyc, m_stb, m_we, m_sel, grant, wbs_ack, wbs_err, la_ack, la_err, irq}, 0);
      chk("t6_async_bus", m_adr | m_dat, 0);
      m_ack = 1; m_rdat = 32'h4;
      #1;
      chk("t6_rst_ack", {la_ack, la_rdat}, 0);
      m_ack = 0;
      @(posedge clk);
      #1;
      rst_n = 1;
      wbs_cyc = 1; wbs_stb = 1; wbs_adr = 32'h80;
      tick;
      chk("t6_m0_first", grant, 2'b01);
      m_ack = 1; m_rdat = 32'h5;
      expect_resp(0, 0, 32'h5);
      tick;
      m_ack = 0; wbs_cyc = 0; wbs_stb = 0; la_req = 0;
      tick; tick;
      chk("scoreboard_drained", q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_dual_master_arbiter.md
Name: wb_dual_master_arbiter

Overview:
- Shares the single Wishbone slave port of the user project core between two requesters:
  - M0: the management SoC Wishbone bus (wbs_*).
  - M1: a logic-analyzer-driven debug requester (la_*).
- Round-robin arbitration, grant held for the whole transaction, watchdog timeout that terminates hung transfers with an error.
- Sits in user_project_wrapper between the top-level wbs_* pins / la_data_in fields and the core's Wishbone slave.

Parameters:
- AW, 32, address width.
- DW, 32, data width; select width is DW/8.
- TO_W, 8, timeout counter width.
- TIMEOUT, 255, cycles in BUSY without m_ack_i before abort; 0 disables the timeout.

Ports:
- wb_clk_i  in  1  clock, all logic rising-edge.
- wb_rst_ni  in  1  reset, asynchronous assert, active-low.
- wbs_cyc_i  in  1  M0 cycle.
- wbs_stb_i  in  1  M0 strobe.
- wbs_we_i  in  1  M0 write enable.
- wbs_sel_i  in  DW/8  M0 byte select.
- wbs_adr_i  in  AW  M0 address.
- wbs_dat_i  in  DW  M0 write data.
- wbs_ack_o  out  1  M0 acknowledge.
- wbs_err_o  out  1  M0 error (timeout).
- wbs_dat_o  out  DW  M0 read data.
- la_req_i  in  1  M1 request, level, held until ack/err.
- la_we_i  in  1  M1 write enable.
- la_adr_i  in  AW  M1 address.
- la_dat_i  in  DW  M1 write data.
- la_ack_o  out  1  M1 acknowledge.
- la_err_o  out  1  M1 error.
- la_dat_o  out  DW  M1 read data.
- m_cyc_o  out  1  core cycle.
- m_stb_o  out  1  core strobe.
- m_we_o  out  1  core write enable.
- m_sel_o  out  DW/8  core byte select.
- m_adr_o  out  AW  core address.
- m_dat_o  out  DW  core write data.
- m_dat_i  in  DW  core read data.
- m_ack_i  in  1  core acknowledge.
- grant_o  out  2  one-hot current owner {M1,M0}; 00 when idle.
- timeout_irq_o  out  1  one-cycle pulse on each timeout abort.

Behaviour:
- States: IDLE, BUSY0, BUSY1, ERR.
- Reset, asynchronous on wb_rst_ni low, including mid-transaction:
  - State goes to IDLE and the timeout counter to 0.
  - last_q goes to 1, so M0 wins the first tie.
  - All outputs go to 0 immediately.
- IDLE:
  - r0 = wbs_cyc_i & wbs_stb_i; r1 = la_req_i.
  - Only r0 set: go to BUSY0. Only r1 set: go to BUSY1.
  - Both set: grant the master that is not last_q.
  - Arbitration latency is one cycle: m_cyc_o/m_stb_o rise the cycle after the request is first seen.
- BUSY0 / BUSY1:
  - m_cyc_o = m_stb_o = 1.
  - m_we_o, m_sel_o, m_adr_o and m_dat_o are combinationally muxed from the owner. For M1, m_sel_o is all-ones.
  - Masters must hold their fields stable until ack/err (Wishbone classic).
  - grant_o is 01 in BUSY0 and 10 in BUSY1.
  - The counter increments each cycle.
  - On m_ack_i:
    - The owner's ack is asserted combinationally in the same cycle.
    - The owner's dat_o equals m_dat_i in that cycle.
    - Next edge: IDLE, last_q = owner, counter cleared.
- IDLE always lasts at least one cycle between transactions. There is no back-to-back regrant on the ack edge.
- Abandon: the owner drops its request mid-BUSY (wbs_cyc_i low for M0, la_req_i low for M1).
  - Next edge: IDLE, m_cyc_o drops, no ack.
  - last_q is updated to the owner.
  - m_ack_i in the abandon cycle is not forwarded.
- Timeout: counter == TIMEOUT (and TIMEOUT != 0) with no m_ack_i in that cycle.
  - Go to ERR.
  - ERR lasts one cycle:
    - m_cyc_o = m_stb_o = 0.
    - The owner's err = 1.
    - timeout_irq_o = 1.
    - grant_o holds the owner.
  - Then IDLE, last_q = owner.
- m_ack_i and the timeout in the same cycle: the ack wins and no error is raised.
- m_ack_i in IDLE or ERR is ignored.
- The non-owner's ack/err/dat_o are always 0. The owner's dat_o is 0 outside its ack cycle.
- ack and err are never both high.

Test Plan:
- Reset, then M0 read at 0x3000_0004; core acks on the 2nd BUSY cycle with 0xDEAD_BEEF.
  - m_cyc_o rises 1 cycle after stb.
  - wbs_ack_o is high one cycle with wbs_dat_o = 0xDEAD_BEEF.
  - grant_o goes 00 -> 01 -> 00.
- r0 and r1 raised in the same cycle, both held and re-requested after each ack:
  - Grants alternate M0, M1, M0, M1.
  - la_ack_o never coincides with wbs_ack_o.
- M1 write 0x1234_5678 to 0x10 while M0 requests mid-transfer:
  - m_adr_o = 0x10 and m_sel_o = 0xF stay stable until la_ack_o.
  - M0 is granted after one IDLE cycle.
- Core never acks, TIMEOUT = 255:
  - Exactly 256 BUSY cycles, then one ERR cycle with wbs_err_o = 1 and timeout_irq_o = 1.
  - Then IDLE; a later stray m_ack_i produces no ack.
- M0 drops wbs_cyc_i in the 3rd BUSY cycle:
  - m_cyc_o = 0 the next cycle, no ack/err.
  - M1 is granted on the next request.
- wb_rst_ni pulsed low mid-BUSY1:
  - All outputs go to 0 asynchronously before the next edge.
  - After release, a simultaneous request is granted to M0.
